// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, data-memory defaults
// and the memory-access controller state encoding.
package mips_pkg;

    localparam int WORD_W         = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int DATA_MEM_BASE  = 1024;
    localparam int DATA_MEM_DEPTH = 64;

    // Memory-access controller states; the encoding is fixed for legacy dumps.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_fsm_e;

    // A word access is misaligned when either of the two byte-offset bits is set.
    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM -> MEM/WB bundle. The pipeline side (master) drives the *_in
// fields and observes the stage results; the memory stage is the slave.
interface mem_stage_if import mips_pkg::*; ;

    logic [WORD_W-1:0]     PC_in;
    logic                  WB_EN_in;
    logic                  MEM_R_EN_in;
    logic                  MEM_W_EN_in;
    logic [WORD_W-1:0]     ALU_result_in;
    logic [WORD_W-1:0]     ST_val_in;
    logic [REG_ADDR_W-1:0] Dest_in;

    logic [WORD_W-1:0]     PC;
    logic                  WB_EN;
    logic                  MEM_R_EN;
    logic [WORD_W-1:0]     ALU_result;
    logic [REG_ADDR_W-1:0] Dest;
    logic [WORD_W-1:0]     MEM_read_value;
    logic                  freeze;

    modport master (
        output PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in,
        input  PC, WB_EN, MEM_R_EN, ALU_result, Dest, MEM_read_value, freeze
    );

    modport slave (
        input  PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in,
        output PC, WB_EN, MEM_R_EN, ALU_result, Dest, MEM_read_value, freeze
    );

endinterface

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: byte address -> word index translation, range
// check, asynchronous read and a write port on the rising clock edge.
// Contents are never cleared by reset.
module data_memory import mips_pkg::*; #(
    parameter int DEPTH     = DATA_MEM_DEPTH,
    parameter int BASE_ADDR = DATA_MEM_BASE
) (
    input  logic              i_clk,
    input  logic [WORD_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_in_range
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] w_off;
    logic [AW-1:0]     w_idx;

    // Addresses below the base wrap to a huge offset, so one unsigned compare
    // covers both ends of the window.
    assign w_off      = i_addr - WORD_W'(BASE_ADDR);
    assign w_idx      = w_off[AW+1:2];
    assign o_in_range = (w_off < WORD_W'(4 * DEPTH));
    assign o_rdata    = r_mem[w_idx];

    // Commit a store only when the address falls inside the memory window.
    always_ff @(posedge i_clk) begin
        if (i_we && o_in_range) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: LW/SW against the data memory with a WAIT_CYCLES access
// latency, freeze while an access is in flight, and pass-through of the
// EX/MEM fields to the MEM/WB register.
// Optional build macro MEM_ACCESS_CHECK_EN adds the sticky mem_err output.
module mem_stage import mips_pkg::*; #(
    parameter int DEPTH       = DATA_MEM_DEPTH,
    parameter int BASE_ADDR   = DATA_MEM_BASE,
    parameter int WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    mem_stage_if.slave bus
`ifdef MEM_ACCESS_CHECK_EN
    ,
    output logic mem_err
`endif
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_fsm_e          r_state;
    mem_fsm_e          w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              w_req;
    logic              w_is_read;
    logic              w_complete;
    logic              w_fire;
    logic              w_freeze;
    logic              w_in_range;
    logic [WORD_W-1:0] w_rdata;

    // A simultaneous load+store request is treated as a store.
    assign w_req     = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
    assign w_is_read = bus.MEM_R_EN_in & ~bus.MEM_W_EN_in;
    // Reset aborts any access that would otherwise complete this cycle.
    assign w_fire    = w_complete & ~rst;

    data_memory #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_dmem (
        .i_clk      (clk),
        .i_addr     (bus.ALU_result_in),
        .i_we       (w_fire & bus.MEM_W_EN_in),
        .i_wdata    (bus.ST_val_in),
        .o_rdata    (w_rdata),
        .o_in_range (w_in_range)
    );

    // Wait-state controller: decide freeze, completion and the next state/count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_freeze    = 1'b0;
        w_complete  = 1'b0;
        if (WAIT_CYCLES == 0) begin
            w_complete = w_req;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        w_freeze    = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = BUSY;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        w_freeze  = 1'b1;
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_complete  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Controller state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Load data is presented only on the completion cycle of an in-range load.
    always_comb begin
        if (w_fire && w_is_read && w_in_range) begin
            bus.MEM_read_value = w_rdata;
        end else begin
            bus.MEM_read_value = {WORD_W{1'b0}};
        end
    end

    assign bus.freeze     = w_freeze;
    assign bus.PC         = bus.PC_in;
    assign bus.WB_EN      = bus.WB_EN_in;
    assign bus.MEM_R_EN   = bus.MEM_R_EN_in;
    assign bus.ALU_result = bus.ALU_result_in;
    assign bus.Dest       = bus.Dest_in;

`ifdef MEM_ACCESS_CHECK_EN
    logic r_mem_err;

    // Sticky error on any completed access that is out of range or misaligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else if (w_fire && (!w_in_range || is_misaligned(bus.ALU_result_in))) begin
            r_mem_err <= 1'b1;
        end else begin
            r_mem_err <= r_mem_err;
        end
    end

    assign mem_err = r_mem_err;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances with WAIT_CYCLES 0, 3 and 2.
// Index 0 -> WAIT_CYCLES=0, index 1 -> 3, index 2 -> 2.
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  t_rst, t_wb, t_rd, t_wr;
    logic [31:0] t_pc [3];
    logic [31:0] t_alu [3];
    logic [31:0] t_st [3];
    logic [4:0]  t_dest [3];

    logic [2:0]  o_frz, o_wb, o_ren, o_err;
    logic [31:0] o_pc [3];
    logic [31:0] o_alu [3];
    logic [31:0] o_rdv [3];
    logic [4:0]  o_dest [3];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
        mem_stage_if bus ();
        assign bus.PC_in         = t_pc[g];
        assign bus.WB_EN_in      = t_wb[g];
        assign bus.MEM_R_EN_in   = t_rd[g];
        assign bus.MEM_W_EN_in   = t_wr[g];
        assign bus.ALU_result_in = t_alu[g];
        assign bus.ST_val_in     = t_st[g];
        assign bus.Dest_in       = t_dest[g];
        assign o_frz[g]  = bus.freeze;
        assign o_wb[g]   = bus.WB_EN;
        assign o_ren[g]  = bus.MEM_R_EN;
        assign o_pc[g]   = bus.PC;
        assign o_alu[g]  = bus.ALU_result;
        assign o_rdv[g]  = bus.MEM_read_value;
        assign o_dest[g] = bus.Dest;
`ifdef MEM_ACCESS_CHECK_EN
        mem_stage #(.WAIT_CYCLES(W)) u_dut (.clk(clk), .rst(t_rst[g]), .bus(bus.slave), .mem_err(o_err[g]));
`else
        assign o_err[g] = 1'b0;
        mem_stage #(.WAIT_CYCLES(W)) u_dut (.clk(clk), .rst(t_rst[g]), .bus(bus.slave));
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        t_rd[k]   = rd;
        t_wr[k]   = wr;
        t_wb[k]   = rd;
        t_alu[k]  = addr;
        t_st[k]   = data;
        t_pc[k]   = 32'h0000_0400;
        t_dest[k] = 5'd3;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Issue one access held for w+1 cycles; freeze must be high for the
    // first w cycles and the load value must appear on the last one.
    task automatic access(input int k, input int w, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd, input string tag);
        drive(k, rd, wr, addr, data);
        for (int c = 0; c <= w; c++) begin
            #2;
            check({tag, "_frz"}, {31'b0, o_frz[k]}, (c < w) ? 32'd1 : 32'd0);
            if (c == w) check({tag, "_rd"}, o_rdv[k], exp_rd);
            tick();
        end
        idle(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        t_rst = 3'b111;
        for (int k = 0; k < 3; k++) idle(k);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check("rst_frz", {31'b0, o_frz[k]}, 32'd0);
            check("rst_rd", o_rdv[k], 32'd0);
            check("rst_err", {31'b0, o_err[k]}, 32'd0);
        end
        t_rst = 3'b000;
        tick();

        // WAIT_CYCLES=0: store then same-cycle load, no freeze.
        access(0, 0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 32'h0, "w0_sw");
        drive(0, 1'b1, 1'b0, 32'd1028, 32'h0);
        #2;
        check("w0_lw_ren", {31'b0, o_ren[0]}, 32'd1);
        tick();
        idle(0);
        access(0, 0, 1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEAD_BEEF, "w0_lw");
        // Both enables: store only, no load data.
        access(0, 0, 1'b1, 1'b1, 32'd1028, 32'h1357_9BDF, 32'h0, "w0_both");
        access(0, 0, 1'b1, 1'b0, 32'd1028, 32'h0, 32'h1357_9BDF, "w0_both_rb");
        // Out of range: preload neighbours, then LW at 0 and SW just past the end.
        access(0, 0, 1'b0, 1'b1, 32'd1024, 32'h0102_0304, 32'h0, "oor_pre0");
        access(0, 0, 1'b0, 1'b1, 32'd1276, 32'h600D_CAFE, 32'h0, "oor_pre63");
        access(0, 0, 1'b1, 1'b0, 32'd0, 32'h0, 32'h0, "oor_lw");
`ifdef MEM_ACCESS_CHECK_EN
        check("oor_err_set", {31'b0, o_err[0]}, 32'd1);
`endif
        access(0, 0, 1'b0, 1'b1, 32'd1280, 32'h7777_7777, 32'h0, "oor_sw");
        access(0, 0, 1'b1, 1'b0, 32'd1024, 32'h0, 32'h0102_0304, "oor_w0");
        access(0, 0, 1'b1, 1'b0, 32'd1028, 32'h0, 32'h1357_9BDF, "oor_w1");
        access(0, 0, 1'b1, 1'b0, 32'd1276, 32'h0, 32'h600D_CAFE, "oor_w63");
`ifdef MEM_ACCESS_CHECK_EN
        check("oor_err_sticky", {31'b0, o_err[0]}, 32'd1);
        t_rst[0] = 1'b1;
        tick();
        t_rst[0] = 1'b0;
        check("oor_err_clr", {31'b0, o_err[0]}, 32'd0);
`endif
        // Pass-through of a non-memory instruction.
        t_pc[0] = 32'h0000_0100; t_wb[0] = 1'b1; t_rd[0] = 1'b0; t_wr[0] = 1'b0;
        t_alu[0] = 32'h55; t_dest[0] = 5'd7; t_st[0] = 32'h0;
        #2;
        check("pt_pc", o_pc[0], 32'h0000_0100);
        check("pt_wb", {31'b0, o_wb[0]}, 32'd1);
        check("pt_ren", {31'b0, o_ren[0]}, 32'd0);
        check("pt_alu", o_alu[0], 32'h55);
        check("pt_dest", {27'b0, o_dest[0]}, 32'd7);
        check("pt_frz", {31'b0, o_frz[0]}, 32'd0);
        check("pt_rd", o_rdv[0], 32'd0);
        tick();
        idle(0);

        // WAIT_CYCLES=3: store then back-to-back loads, 3 freeze cycles each.
        access(1, 3, 1'b0, 1'b1, 32'd1024, 32'h1234_5678, 32'h0, "w3_sw");
        access(1, 3, 1'b1, 1'b0, 32'd1024, 32'h0, 32'h1234_5678, "w3_lw");
        access(1, 3, 1'b1, 1'b0, 32'd1024, 32'h0, 32'h1234_5678, "w3_b2b");

        // WAIT_CYCLES=2: the word changes only on the completion edge.
        access(2, 2, 1'b0, 1'b1, 32'd1032, 32'h1111_1111, 32'h0, "w2_pre");
        drive(2, 1'b0, 1'b1, 32'd1032, 32'hA5A5_A5A5);
        for (int c = 0; c < 3; c++) begin
            #2;
            check("w2_hold_mem", g_dut[2].u_dut.u_dmem.r_mem[2], 32'h1111_1111);
            check("w2_hold_frz", {31'b0, o_frz[2]}, (c < 2) ? 32'd1 : 32'd0);
            tick();
        end
        idle(2);
        check("w2_commit_mem", g_dut[2].u_dut.u_dmem.r_mem[2], 32'hA5A5_A5A5);
        access(2, 2, 1'b1, 1'b0, 32'd1032, 32'h0, 32'hA5A5_A5A5, "w2_rb");

        // WAIT_CYCLES=3: reset in the 2nd BUSY cycle aborts the store.
        access(1, 3, 1'b0, 1'b1, 32'd1040, 32'h0BAD_F00D, 32'h0, "abort_pre");
        drive(1, 1'b0, 1'b1, 32'd1040, 32'hFFFF_FFFF);
        #2;
        check("abort_frz0", {31'b0, o_frz[1]}, 32'd1);
        tick();
        tick();
        t_rst[1] = 1'b1;
        tick();
        t_rst[1] = 1'b0;
        idle(1);
        #2;
        check("abort_frz_drop", {31'b0, o_frz[1]}, 32'd0);
        tick();
        access(1, 3, 1'b1, 1'b0, 32'd1040, 32'h0, 32'h0BAD_F00D, "abort_rb");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register (mem_stage_reg).
- Holds the word-addressed data memory and executes LW/SW.
- Models a configurable access latency with a wait-state counter, and raises freeze to stall the pipeline while an access is in flight.
- Passes PC, WB_EN, MEM_R_EN, ALU_result and Dest through to the MEM/WB register.

Parameters:
- DEPTH, 64: data memory size in 32-bit words (power of 2).
- BASE_ADDR, 1024: byte address mapped to word 0.
- WAIT_CYCLES, 0: extra cycles per memory access, range 0..15.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset.
- PC_in  in  32  PC from the EX/MEM register.
- WB_EN_in  in  1  writeback enable.
- MEM_R_EN_in  in  1  load.
- MEM_W_EN_in  in  1  store.
- ALU_result_in  in  32  effective byte address, or ALU value.
- ST_val_in  in  32  store data.
- Dest_in  in  5  destination register.
- PC  out  32  pass-through of PC_in.
- WB_EN  out  1  pass-through.
- MEM_R_EN  out  1  pass-through.
- ALU_result  out  32  pass-through.
- Dest  out  5  pass-through.
- MEM_read_value  out  32  load data.
- freeze  out  1  stall request to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset:
  - FSM goes to IDLE, wait counter to 0, freeze 0.
  - Data memory contents are NOT cleared.
  - Pass-through outputs follow their inputs (they are combinational).
  - MEM_read_value is 0 while the FSM is not completing a read.
- Address mapping:
  - idx = (ALU_result_in - BASE_ADDR) >> 2, a 32-bit subtraction.
  - In range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
  - Low 2 address bits are ignored.
- Access request: req = MEM_R_EN_in | MEM_W_EN_in.
  - MEM_R_EN_in and MEM_W_EN_in both 1 is treated as a store only; MEM_read_value is 0.
- FSM states: IDLE, BUSY.
  - IDLE with req and WAIT_CYCLES>0: freeze=1 combinationally; counter loads WAIT_CYCLES-1; next state is BUSY.
  - BUSY with counter>0: freeze=1, counter decrements.
  - BUSY with counter==0: completion cycle. freeze=0, the access takes effect, next state is IDLE.
  - WAIT_CYCLES==0: every access completes in its first cycle; freeze is never asserted.
  - Latency: a load/store occupies the stage for exactly WAIT_CYCLES+1 cycles, with freeze high for the first WAIT_CYCLES of them.
- Completion cycle:
  - Read: MEM_read_value = mem[idx], asynchronous array read, valid in the cycle freeze is 0.
  - Write: mem[idx] <= ST_val_in at that posedge.
  - Out-of-range read returns 0. Out-of-range write is dropped.
- Writes only occur on the completion edge, never while freeze=1. A stalled store therefore never commits twice.
- Inputs are held stable by upstream while freeze=1. The block does not latch them.
- rst during BUSY aborts the access: no write, state goes to IDLE, freeze drops in the next cycle.
- Back-to-back accesses: from IDLE, a new request is serviced on the cycle after completion, and the counter is reloaded.

Optional Feature:
- Macro: MEM_ACCESS_CHECK_EN.
- With the macro defined:
  - Extra output mem_err (1 bit): a sticky flag set on the completion cycle of any access that is out of range or has ALU_result_in[1:0] != 0.
  - mem_err is cleared only by rst.
  - Misaligned accesses still proceed with the low bits ignored.
- Without the macro: no mem_err port, and no check logic.

Decomposition:
- Shared package mips_pkg holds:
  - WORD_W=32, REG_ADDR_W=5.
  - Default DATA_MEM_BASE=1024, DATA_MEM_DEPTH=64.
  - FSM state typedef for the memory access controller {IDLE, BUSY}.
- One sub-module: data_memory. It provides the array, address translation and range check, with combinational read and write on clk.
- mem_stage contains the FSM, the wait counter, the output muxing and the optional check.

Test Plan:
- WAIT_CYCLES=0: SW with ALU_result_in=1028, ST_val_in=0xDEADBEEF, then LW from 1028 -> MEM_read_value=0xDEADBEEF in the same cycle; freeze stays 0 throughout.
- WAIT_CYCLES=3: LW from 1024 holding 0x12345678 -> freeze=1 for exactly 3 cycles, then 0 with MEM_read_value=0x12345678; FSM back in IDLE.
- WAIT_CYCLES=2: SW of 0xA5A5A5A5 to 1032, with inputs held -> the word changes only on the completion edge; a read-back of 1032 afterwards returns 0xA5A5A5A5.
- WAIT_CYCLES=3: rst pulsed in the 2nd BUSY cycle of a SW to 1040 -> freeze=0 next cycle; mem[4] is unchanged.
- Out of range: LW at 0 and SW at 1024+4*64 -> read returns 0, no memory word changes. With MEM_ACCESS_CHECK_EN, mem_err=1 and stays 1 until rst.
- Pass-through: non-memory instruction with ALU_result_in=0x55, Dest_in=7, WB_EN_in=1 -> outputs equal inputs, freeze=0.
